serial_demux: RTL and testbench

Time-division demultiplexer, the receiving end of the bit-serial datapath built from the `yMux1` select chain. Routes each accepted serial bit into the next bit position of a WIDTH-bit word, then presents the assembled word on a parallel valid/ready output holding a one-word buffer. Sits between the serializer/bit-select stage and the register-file/ALU operand inputs in the lab CPU.

---
 rtl/serial_demux.sv | 113 +++++++++++
 tb/tb_serial_demux.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_demux.sv
// Bit-serial to parallel demultiplexer with a one-word valid/ready output buffer.
// Optional even-parity bit per word when SERIAL_DEMUX_PARITY_EN is defined.
module serial_demux #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_perr
);

  localparam int CW = $clog2(WIDTH + 2);
`ifdef SERIAL_DEMUX_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif

  typedef enum logic {S_COLLECT, S_HOLD} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic [CW-1:0]    w_pos;
  logic [WIDTH-1:0] w_shreg_nx;
  logic             w_last;
  logic             w_take;

`ifdef SERIAL_DEMUX_PARITY_EN
  logic r_par;
  logic r_perr;
  assign out_perr = r_perr;
`else
  assign out_perr = 1'b0;
`endif

  assign in_ready  = (r_state == S_COLLECT);
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign w_take    = r_valid & out_ready;
  assign w_last    = (r_cnt == CW'(N - 1));

  // With parity, the count reaching WIDTH selects no data bit, so the parity bit never lands in shreg.
  assign w_pos = MSB_FIRST ? (CW'(WIDTH - 1) - r_cnt) : r_cnt;

  for (genvar g = 0; g < WIDTH; g++) begin : g_steer
    assign w_shreg_nx[g] = (w_pos == CW'(g)) ? in_bit : r_shreg[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COLLECT;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
`ifdef SERIAL_DEMUX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      // A consumed word empties the buffer unless a new word is loaded below.
      if (w_take) r_valid <= 1'b0;

      if (clr) begin
        r_state <= S_COLLECT;
        r_cnt   <= '0;
        r_shreg <= '0;
      end else if (r_state == S_HOLD) begin
        if (w_take) begin
          r_data  <= r_shreg;
          r_valid <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_COLLECT;
`ifdef SERIAL_DEMUX_PARITY_EN
          r_perr  <= ^r_shreg ^ r_par;
`endif
        end
      end else if (in_valid) begin
        r_shreg <= w_shreg_nx;
        if (w_last) begin
`ifdef SERIAL_DEMUX_PARITY_EN
          r_par <= in_bit;
`endif
          if (!r_valid || out_ready) begin
            r_data  <= w_shreg_nx;
            r_valid <= 1'b1;
            r_cnt   <= '0;
`ifdef SERIAL_DEMUX_PARITY_EN
            r_perr  <= ^r_shreg ^ in_bit;
`endif
          end else begin
            r_state <= S_HOLD;
            r_cnt   <= CW'(N);
          end
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_demux.sv
// Scoreboard bench for serial_demux: LSB-first and MSB-first instances share one stimulus stream.
module tb_serial_demux;

  localparam int W = 8;
`ifdef SERIAL_DEMUX_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_bit = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic rdy0, rdy1, val0, val1, perr0, perr1;
  logic [W-1:0] d0, d1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  bit           mq[$];
  logic [W-1:0] sb0[$];
  logic [W-1:0] sb1[$];
  logic         sbp[$];
  int           mdl_words = 0;

  logic [W-1:0] e0, e1;
  logic         ep;

  always #5 clk = ~clk;

  serial_demux #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(rdy0), .out_data(d0), .out_valid(val0), .out_ready(out_ready), .out_perr(perr0));

  serial_demux #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(rdy1), .out_data(d1), .out_valid(val1), .out_ready(out_ready), .out_perr(perr1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: words in flight (output buffer plus held word) and the bits of the partial word.
  task automatic model_update();
    bit take;
    logic [W-1:0] w0, w1;
    logic p;
    take = (mdl_words > 0) && out_ready;
    if (clr) begin
      mq.delete();
      if (mdl_words == 2) begin
        void'(sb0.pop_back()); void'(sb1.pop_back()); void'(sbp.pop_back());
        mdl_words = 1;
      end
    end else if (in_valid && mdl_words < 2) begin
      mq.push_back(in_bit);
      if (mq.size() == N) begin
        w0 = '0; w1 = '0; p = 1'b0;
        for (int i = 0; i < N; i++) begin
          p ^= mq[i];
          if (i < W) begin
            w0[i]       = mq[i];
            w1[W-1-i]   = mq[i];
          end
        end
`ifndef SERIAL_DEMUX_PARITY_EN
        p = 1'b0;
`endif
        sb0.push_back(w0); sb1.push_back(w1); sbp.push_back(p);
        mq.delete();
        mdl_words++;
      end
    end
    if (take) mdl_words--;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic send_raw(input logic [W-1:0] v, input logic p);
    for (int i = 0; i < W; i++) begin
      in_valid = 1'b1; in_bit = v[i]; tick();
    end
`ifdef SERIAL_DEMUX_PARITY_EN
    in_valid = 1'b1; in_bit = p; tick();
`endif
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] v);
    send_raw(v, ^v);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_lsb", {31'b0, rdy0}, {31'b0, mdl_words < 2});
      chk("in_ready_msb", {31'b0, rdy1}, {31'b0, mdl_words < 2});
      chk("out_valid_lsb", {31'b0, val0}, {31'b0, mdl_words > 0});
      chk("out_valid_msb", {31'b0, val1}, {31'b0, mdl_words > 0});
      if (mdl_words > 0 && out_ready) begin
        if (sb0.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL scoreboard_empty: got handshake expected queued word at %0t", $time);
        end else begin
          e0 = sb0.pop_front(); e1 = sb1.pop_front(); ep = sbp.pop_front();
          chk("data_lsb", {24'b0, d0}, {24'b0, e0});
          chk("data_msb", {24'b0, d1}, {24'b0, e1});
          chk("perr_lsb", {31'b0, perr0}, {31'b0, ep});
          chk("perr_msb", {31'b0, perr1}, {31'b0, ep});
        end
      end
    end
  end

  initial begin
    logic [W-1:0] v;
    #1;
    chk("rst_data", {24'b0, d0}, 32'h0);
    chk("rst_valid", {31'b0, val0}, 32'h0);
    chk("rst_perr", {31'b0, perr0}, 32'h0);
    chk("rst_in_ready", {31'b0, rdy0}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    out_ready = 1'b1;
    send_word(8'h4D);
    chk("dir_lsb_4D", {24'b0, d0}, 32'h4D);
    chk("dir_msb_B2", {24'b0, d1}, 32'hB2);
    chk("dir_valid", {31'b0, val0}, 32'h1);
    tick();

    out_ready = 1'b0;
    send_word(8'hFF);
    send_word(8'h01);
    chk("stall_in_ready", {31'b0, rdy0}, 32'h0);
    chk("stall_data_FF", {24'b0, d0}, 32'hFF);
    out_ready = 1'b1;
    tick();
    chk("release_data_01", {24'b0, d0}, 32'h01);
    chk("release_valid", {31'b0, val0}, 32'h1);
    chk("release_in_ready", {31'b0, rdy0}, 32'h1);
    tick();

    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_bit = 1'($urandom); tick();
    end
    clr = 1'b1; in_valid = 1'b1; in_bit = 1'b1; tick();
    clr = 1'b0;
    send_word(8'hA5);
    chk("clr_lsb_A5", {24'b0, d0}, 32'hA5);
    chk("clr_msb_A5", {24'b0, d1}, 32'hA5);
    tick();

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bit = 1'($urandom); tick();
    end
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, val0}, 32'h0);
    chk("async_rst_data", {24'b0, d0}, 32'h0);
    chk("async_rst_in_ready", {31'b0, rdy0}, 32'h1);
    mq.delete(); sb0.delete(); sb1.delete(); sbp.delete(); mdl_words = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    v = W'($urandom);
    send_word(v);
    chk("post_rst_word", {24'b0, d0}, {24'b0, v});
    tick();

`ifdef SERIAL_DEMUX_PARITY_EN
    send_raw(8'h03, 1'b0);
    chk("parity_ok", {31'b0, perr0}, 32'h0);
    send_raw(8'h03, 1'b1);
    chk("parity_err", {31'b0, perr0}, 32'h1);
    tick();
`endif

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bit    = 1'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      clr       = ($urandom_range(0, 31) == 0);
      tick();
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("drained_valid", {31'b0, val0}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
